mem_port_arbiter: RTL and testbench

- Sits directly upstream of storage_controller.
- Accepts two core-side request/grant memory ports: instruction fetch (read-only) and vector/scalar data (read/write).
- Arbitrates between them and serialises one access at a time into storage_controller's level-held memory_access interface.
- Returns the result to the originating port as a one-cycle rvalid pulse. External-region writes, out-of-range addresses, programming-mode conflicts and timeouts are decided locally and reported as errors.

---
 rtl/storage_pkg.sv | 7 +
 rtl/mem_rr_arbiter.sv | 18 +
 rtl/mem_port_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/storage_pkg.sv
// storage_pkg: shared types and constants for the memory port arbiter and its round-robin core.
package storage_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} arb_state_e;
    typedef enum logic {PORT_INSTR, PORT_DATA} port_id_e;
    localparam logic [31:0] DEF_SRAM_LIMIT = 32'h0000_1000;
    localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;
endpackage

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: two-input round-robin arbiter; priority moves away from a port only when it is granted.
module mem_rr_arbiter
    import storage_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    port_id_e prio;
    assign gnt[0] = en & req[0] & (~req[1] | (prio == PORT_INSTR));
    assign gnt[1] = en & req[1] & (~req[0] | (prio == PORT_DATA));
    always_ff @(posedge clk) begin
        if (!rst) prio <= PORT_INSTR;
        else if (|gnt) prio <= gnt[0] ? PORT_DATA : PORT_INSTR;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises instruction and data ports, one access at a time, onto storage_controller.
module mem_port_arbiter
    import storage_pkg::*;
#(
    parameter int unsigned MEM_W          = 32,
    parameter int unsigned MEM_SZ         = 262144,
    parameter logic [31:0] SRAM_LIMIT     = DEF_SRAM_LIMIT,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_req,
    input  logic [31:0]        i_addr,
    output logic               i_gnt,
    output logic               i_rvalid,
    output logic [MEM_W-1:0]   i_rdata,
    output logic               i_err,
    input  logic               d_req,
    input  logic               d_we,
    input  logic [MEM_W/8-1:0] d_be,
    input  logic [31:0]        d_addr,
    input  logic [MEM_W-1:0]   d_wdata,
    output logic               d_gnt,
    output logic               d_rvalid,
    output logic [MEM_W-1:0]   d_rdata,
    output logic               d_err,
    input  logic               prog_mode,
    output logic               sc_memory_access,
    output logic               sc_is_writing,
    output logic [31:0]        sc_addr,
    output logic [MEM_W-1:0]   sc_wdata,
    output logic [MEM_W/8-1:0] sc_be,
    output logic               sc_external,
    input  logic [MEM_W-1:0]   sc_rdata,
    input  logic               sc_valid
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    arb_state_e         state;
    port_id_e           port;
    logic [31:0]        acc_addr;
    logic               acc_we;
    logic [MEM_W/8-1:0] acc_be;
    logic [MEM_W-1:0]   acc_wdata;
    logic [MEM_W-1:0]   rdata;
    logic               err;
    logic [CW-1:0]      cnt;
    logic [1:0]         gnt;
    logic [31:0]        sel_addr;
    logic               sel_we, bad, issue, resp, timed_out;

    mem_rr_arbiter u_arb (
        .clk (clk),
        .rst (rst),
        .en  (rst & (state == IDLE) & ~prog_mode),
        .req ({d_req, i_req}),
        .gnt (gnt)
    );

    assign i_gnt     = gnt[0];
    assign d_gnt     = gnt[1];
    assign sel_addr  = gnt[1] ? d_addr : i_addr;
    assign sel_we    = gnt[1] & d_we;
    // External QSPI is read-only from the core side, so writes there never reach the controller
    assign bad       = (sel_addr >= MEM_SZ) | ((sel_addr >= SRAM_LIMIT) & sel_we);
    assign issue     = state == ISSUE;
    assign resp      = state == RESP;
    assign timed_out = cnt == CW'(TIMEOUT_CYCLES - 1);

    assign sc_memory_access = issue;
    assign sc_is_writing    = issue & acc_we;
    assign sc_addr          = issue ? acc_addr : '0;
    assign sc_wdata         = issue ? acc_wdata : '0;
    assign sc_be            = issue ? acc_be : '0;
    assign sc_external      = issue & (acc_addr >= SRAM_LIMIT);

    assign i_rvalid = resp & (port == PORT_INSTR);
    assign d_rvalid = resp & (port == PORT_DATA);
    assign i_rdata  = i_rvalid ? rdata : '0;
    assign d_rdata  = d_rvalid ? rdata : '0;
    assign i_err    = i_rvalid & err;
    assign d_err    = d_rvalid & err;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            port      <= PORT_INSTR;
            acc_addr  <= '0;
            acc_we    <= 1'b0;
            acc_be    <= '0;
            acc_wdata <= '0;
            rdata     <= '0;
            err       <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: if (|gnt) begin
                    port      <= gnt[1] ? PORT_DATA : PORT_INSTR;
                    acc_addr  <= sel_addr;
                    acc_we    <= sel_we;
                    acc_be    <= gnt[1] ? d_be : '1;
                    acc_wdata <= gnt[1] ? d_wdata : '0;
                    rdata     <= '0;
                    err       <= bad;
                    cnt       <= '0;
                    state     <= bad ? RESP : ISSUE;
                end
                ISSUE: begin
                    cnt <= cnt + 1'b1;
                    // The controller never completes while programming, so that is treated as a timeout
                    if (sc_valid) begin
                        rdata <= acc_we ? '0 : sc_rdata;
                        err   <= 1'b0;
                        state <= RESP;
                    end else if (timed_out | prog_mode) begin
                        rdata <= MEM_W'(ERR_RDATA);
                        err   <= 1'b1;
                        state <= RESP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_mem_port_arbiter;
    localparam int          T    = 8;
    localparam logic [31:0] MSZ  = 32'd262144;
    localparam logic [31:0] SRAM = 32'h0000_1000;

    logic clk = 1'b0;
    logic rst, i_req, d_req, d_we, prog_mode, sc_valid;
    logic [31:0] i_addr, d_addr, d_wdata, sc_rdata;
    logic [3:0]  d_be;
    logic i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err;
    logic [31:0] i_rdata, d_rdata, sc_addr, sc_wdata;
    logic sc_memory_access, sc_is_writing, sc_external;
    logic [3:0] sc_be;

    int checks = 0;
    int failures = 0;
    int resp_lat = 1;
    int issue_cnt = 0;

    logic [31:0] tab_addr [6] = '{32'h2000, 32'h1000, 32'h0FFF, 32'h4_0000, 32'h4_0000, 32'h3_FFFF};
    logic [5:0]  tab_port = 6'b010111;
    logic [5:0]  tab_we   = 6'b000111;
    logic [5:0]  tab_err  = 6'b011011;
    logic [5:0]  tab_ext  = 6'b100000;

    mem_port_arbiter #(.MEM_W(32), .MEM_SZ(262144), .SRAM_LIMIT(32'h1000), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .prog_mode(prog_mode),
        .sc_memory_access(sc_memory_access), .sc_is_writing(sc_is_writing), .sc_addr(sc_addr),
        .sc_wdata(sc_wdata), .sc_be(sc_be), .sc_external(sc_external),
        .sc_rdata(sc_rdata), .sc_valid(sc_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h10) ? 32'h1234_5678 : ({a[15:0], ~a[15:0]} ^ 32'h5A5A_3C3C);
    endfunction

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 7))
            0, 1, 2: return {20'h0, 12'($urandom)};
            3: return 32'h1000 + ($urandom % 32'h3F000);
            4: return 32'h4_0000 + ($urandom % 32'h1000);
            5: return 32'h0FFF;
            6: return 32'h1000;
            default: return ($urandom_range(0, 1) == 1) ? 32'h3_FFFF : 32'h4_0000;
        endcase
    endfunction

    // Storage responder: answers on the resp_lat-th cycle of a held access
    always @(posedge clk) issue_cnt <= sc_memory_access ? issue_cnt + 1 : 0;
    assign sc_valid = sc_memory_access && (issue_cnt == resp_lat - 1);
    assign sc_rdata = sc_valid ? mem_word(sc_addr) : 32'h0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0; i_req = 1'b0; d_req = 1'b0; prog_mode = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; prog_mode = 1'b0; d_we = 1'b0; d_be = 4'hF; d_wdata = 32'h0;
        i_req = 1'b1; d_req = 1'b1; i_addr = 32'h4_0000; d_addr = 32'h4_0000;
        tick();
        @(negedge clk);
        checks++;
        if ({i_gnt, d_gnt, i_rvalid, d_rvalid, i_err, d_err, sc_memory_access, sc_is_writing, sc_external} !== 9'b0 ||
            sc_addr !== 32'h0 || sc_wdata !== 32'h0 || sc_be !== 4'h0 || i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs: gnt=%b%b rvalid=%b%b access=%b addr=%h expected all zero",
                     i_gnt, d_gnt, i_rvalid, d_rvalid, sc_memory_access, sc_addr);
        end
        tick();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({i_gnt, d_gnt} !== 2'b10) begin
            failures++;
            $display("FAIL reset_priority: i_gnt,d_gnt=%b%b expected 10", i_gnt, d_gnt);
        end
        tick();
        i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({i_rvalid, i_err, d_rvalid, sc_memory_access} !== 4'b1100) begin
            failures++;
            $display("FAIL reset_first_err: i_rvalid,i_err,d_rvalid,access=%b expected 1100",
                     {i_rvalid, i_err, d_rvalid, sc_memory_access});
        end
        tick();
    endtask

    task automatic test_sram_read();
        resp_lat = 2;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; d_be = 4'hF;
        @(negedge clk);
        checks++;
        if ({i_gnt, d_gnt} !== 2'b01) begin
            failures++;
            $display("FAIL sram_gnt: i_gnt,d_gnt=%b%b expected 01", i_gnt, d_gnt);
        end
        tick();
        d_req = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            checks++;
            if ({sc_memory_access, sc_external, sc_is_writing, d_rvalid} !== 4'b1000 || sc_addr !== 32'h10 || sc_be !== 4'hF) begin
                failures++;
                $display("FAIL sram_issue_c%0d: access,ext,wr,rvalid=%b addr=%h expected 1000 addr=00000010",
                         c, {sc_memory_access, sc_external, sc_is_writing, d_rvalid}, sc_addr);
            end
            tick();
        end
        i_req = 1'b1; i_addr = 32'h4_0000;
        @(negedge clk);
        checks++;
        if ({d_rvalid, d_err, i_rvalid, sc_memory_access, i_gnt} !== 5'b10000 || d_rdata !== 32'h1234_5678) begin
            failures++;
            $display("FAIL sram_resp: rvalid,err,i_rvalid,access,i_gnt=%b rdata=%h expected 10000 rdata=12345678",
                     {d_rvalid, d_err, i_rvalid, sc_memory_access, i_gnt}, d_rdata);
        end
        tick();
        @(negedge clk);
        checks++;
        if (i_gnt !== 1'b1) begin
            failures++;
            $display("FAIL sram_next_gnt: i_gnt=%b expected 1 at cycle 4", i_gnt);
        end
        tick();
        i_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({i_rvalid, i_err, sc_memory_access} !== 3'b110) begin
            failures++;
            $display("FAIL range_err: i_rvalid,i_err,access=%b expected 110", {i_rvalid, i_err, sc_memory_access});
        end
        tick();
    endtask

    task automatic test_errors();
        logic [1:0]  exp_rv;
        logic [31:0] got_rd;
        logic        got_err;
        resp_lat = 1;
        for (int i = 0; i < 6; i++) begin
            i_req = !tab_port[i]; d_req = tab_port[i]; i_addr = tab_addr[i]; d_addr = tab_addr[i];
            d_we = tab_we[i]; d_be = 4'hF; d_wdata = $urandom;
            exp_rv = tab_port[i] ? 2'b10 : 2'b01;
            @(negedge clk);
            checks++;
            if ({d_gnt, i_gnt} !== exp_rv) begin
                failures++;
                $display("FAIL err_gnt_%0d: d_gnt,i_gnt=%b%b expected %b", i, d_gnt, i_gnt, exp_rv);
            end
            tick();
            i_req = 1'b0; d_req = 1'b0;
            if (!tab_err[i]) begin
                @(negedge clk);
                checks++;
                if ({sc_memory_access, sc_external, sc_is_writing} !== {1'b1, tab_ext[i], tab_we[i]}) begin
                    failures++;
                    $display("FAIL err_issue_%0d: access,ext,wr=%b expected %b", i,
                             {sc_memory_access, sc_external, sc_is_writing}, {1'b1, tab_ext[i], tab_we[i]});
                end
                tick();
            end
            @(negedge clk);
            got_rd  = tab_port[i] ? d_rdata : i_rdata;
            got_err = tab_port[i] ? d_err : i_err;
            checks++;
            if ({d_rvalid, i_rvalid, got_err, sc_memory_access} !== {exp_rv, tab_err[i], 1'b0} ||
                (!tab_err[i] && got_rd !== (tab_we[i] ? 32'h0 : mem_word(tab_addr[i])))) begin
                failures++;
                $display("FAIL err_resp_%0d: rvalid=%b%b err=%b access=%b rdata=%h expected rvalid=%b err=%b",
                         i, d_rvalid, i_rvalid, got_err, sc_memory_access, got_rd, exp_rv, tab_err[i]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp;
        apply_reset();
        resp_lat = 1;
        i_req = 1'b1; i_addr = 32'h40; d_req = 1'b1; d_addr = 32'h80; d_we = 1'b0;
        for (int k = 0; k < 3; k++) begin
            exp = (k % 2 == 1) ? 2'b10 : 2'b01;
            @(negedge clk);
            checks++;
            if ({d_gnt, i_gnt} !== exp) begin
                failures++;
                $display("FAIL alt_gnt_%0d: d_gnt,i_gnt=%b%b expected %b", k, d_gnt, i_gnt, exp);
            end
            tick();
            @(negedge clk);
            checks++;
            if ({sc_memory_access, d_gnt, i_gnt} !== 3'b100) begin
                failures++;
                $display("FAIL alt_issue_%0d: access,gnt=%b expected 100", k, {sc_memory_access, d_gnt, i_gnt});
            end
            tick();
            @(negedge clk);
            checks++;
            if ({d_rvalid, i_rvalid} !== exp || {sc_memory_access, d_gnt, i_gnt} !== 3'b000 ||
                (exp[1] ? d_rdata : i_rdata) !== mem_word(exp[1] ? 32'h80 : 32'h40)) begin
                failures++;
                $display("FAIL alt_resp_%0d: rvalid=%b%b access,gnt=%b expected rvalid=%b access,gnt=000",
                         k, d_rvalid, i_rvalid, {sc_memory_access, d_gnt, i_gnt}, exp);
            end
            tick();
        end
        i_req = 1'b0; d_req = 1'b0;
    endtask

    task automatic test_timeout();
        int n = 0;
        logic rv = 1'b0;
        logic ext_ok = 1'b1;
        logic [31:0] rd = 32'h0;
        logic er = 1'b0;
        resp_lat = 100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000;
        @(negedge clk);
        checks++;
        if (d_gnt !== 1'b1) begin
            failures++;
            $display("FAIL to_gnt: d_gnt=%b expected 1", d_gnt);
        end
        tick();
        d_req = 1'b0;
        for (int c = 0; c < 20 && !rv; c++) begin
            @(negedge clk);
            if (d_rvalid) begin
                rv = 1'b1; rd = d_rdata; er = d_err;
            end else if (sc_memory_access) begin
                n++;
                if (sc_external !== 1'b1) ext_ok = 1'b0;
            end
            tick();
        end
        checks++;
        if (!rv || n != T || !ext_ok || rd !== 32'hDEAD_BEEF || er !== 1'b1) begin
            failures++;
            $display("FAIL timeout: rvalid_seen=%b issue_cycles=%0d ext=%b rdata=%h err=%b expected 1 %0d 1 deadbeef 1",
                     rv, n, ext_ok, rd, er, T);
        end
    endtask

    task automatic test_prog_mode();
        resp_lat = 100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        @(negedge clk);
        checks++;
        if (d_gnt !== 1'b1) begin
            failures++;
            $display("FAIL prog_gnt: d_gnt=%b expected 1", d_gnt);
        end
        tick();
        d_req = 1'b0;
        tick();
        prog_mode = 1'b1;
        @(negedge clk);
        checks++;
        if ({sc_memory_access, d_rvalid} !== 2'b10) begin
            failures++;
            $display("FAIL prog_still_issue: access,rvalid=%b expected 10", {sc_memory_access, d_rvalid});
        end
        tick();
        i_req = 1'b1; i_addr = 32'h4_0000; d_req = 1'b1; d_addr = 32'h80;
        @(negedge clk);
        checks++;
        if ({d_rvalid, d_err, sc_memory_access} !== 3'b110 || d_rdata !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL prog_err_resp: rvalid,err,access=%b rdata=%h expected 110 deadbeef",
                     {d_rvalid, d_err, sc_memory_access}, d_rdata);
        end
        tick();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if ({i_gnt, d_gnt, i_rvalid, d_rvalid, sc_memory_access} !== 5'b0) begin
                failures++;
                $display("FAIL prog_block_%0d: gnt=%b%b rvalid=%b%b access=%b expected all 0",
                         c, i_gnt, d_gnt, i_rvalid, d_rvalid, sc_memory_access);
            end
            tick();
        end
        prog_mode = 1'b0;
        @(negedge clk);
        checks++;
        if ({i_gnt, d_gnt} !== 2'b10) begin
            failures++;
            $display("FAIL prog_release_gnt: i_gnt,d_gnt=%b%b expected 10", i_gnt, d_gnt);
        end
        tick();
        i_req = 1'b0; d_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        logic [31:0] wd;
        wd = $urandom;
        resp_lat = 100;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h30; d_be = 4'h5; d_wdata = wd;
        @(negedge clk);
        checks++;
        if (d_gnt !== 1'b1) begin
            failures++;
            $display("FAIL rmid_gnt: d_gnt=%b expected 1", d_gnt);
        end
        tick();
        d_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({sc_memory_access, sc_is_writing, sc_external} !== 3'b110 || sc_wdata !== wd || sc_be !== 4'h5) begin
            failures++;
            $display("FAIL rmid_write_issue: access,wr,ext=%b wdata=%h be=%h expected 110 %h 5",
                     {sc_memory_access, sc_is_writing, sc_external}, sc_wdata, sc_be, wd);
        end
        tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if ({sc_memory_access, sc_is_writing, sc_external, i_rvalid, d_rvalid, d_err} !== 6'b0 ||
            sc_addr !== 32'h0 || sc_wdata !== 32'h0 || sc_be !== 4'h0) begin
            failures++;
            $display("FAIL rmid_cleared: access=%b rvalid=%b%b addr=%h expected all zero",
                     sc_memory_access, i_rvalid, d_rvalid, sc_addr);
        end
        tick();
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if ({i_rvalid, d_rvalid, sc_memory_access} !== 3'b000) begin
                failures++;
                $display("FAIL rmid_no_resp_%0d: rvalid=%b%b access=%b expected 000", c, i_rvalid, d_rvalid, sc_memory_access);
            end
            tick();
        end
    endtask

    task automatic test_random();
        int          busy_left = 0;
        logic        last_d = 1'b1;
        logic        exp_port = 1'b0;
        logic        exp_err = 1'b0;
        logic        exp_we = 1'b0;
        logic [31:0] exp_data = 32'h0;
        logic [31:0] exp_addr = 32'h0;
        logic [1:0]  exp_gnt, exp_rv;
        logic [31:0] a;
        logic        we;
        apply_reset();
        for (int c = 0; c < 2000; c++) begin
            if (!i_req && $urandom_range(0, 2) == 0) begin
                i_req = 1'b1; i_addr = rand_addr();
            end
            if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1'b1; d_addr = rand_addr(); d_we = 1'($urandom); d_be = 4'($urandom); d_wdata = $urandom;
            end
            if (busy_left == 0) resp_lat = $urandom_range(1, 10);
            @(negedge clk);
            exp_gnt = 2'b00;
            if (busy_left == 0) begin
                if (i_req && (!d_req || last_d)) exp_gnt = 2'b01;
                else if (d_req) exp_gnt = 2'b10;
            end
            exp_rv = (busy_left == 1) ? (exp_port ? 2'b10 : 2'b01) : 2'b00;
            checks++;
            if ({d_gnt, i_gnt} !== exp_gnt || {d_rvalid, i_rvalid} !== exp_rv) begin
                failures++;
                $display("FAIL rand_handshake c%0d: gnt=%b%b rvalid=%b%b expected gnt=%b rvalid=%b",
                         c, d_gnt, i_gnt, d_rvalid, i_rvalid, exp_gnt, exp_rv);
            end
            if (busy_left == 1) begin
                checks++;
                if ((exp_port ? d_err : i_err) !== exp_err || (!exp_err && (exp_port ? d_rdata : i_rdata) !== exp_data) ||
                    (exp_err && busy_left == 1 && exp_data == 32'hDEAD_BEEF && (exp_port ? d_rdata : i_rdata) !== exp_data)) begin
                    failures++;
                    $display("FAIL rand_resp c%0d: err=%b rdata=%h expected err=%b rdata=%h",
                             c, exp_port ? d_err : i_err, exp_port ? d_rdata : i_rdata, exp_err, exp_data);
                end
            end
            if (sc_memory_access) begin
                checks++;
                if (sc_addr !== exp_addr || sc_is_writing !== exp_we) begin
                    failures++;
                    $display("FAIL rand_issue c%0d: addr=%h wr=%b expected %h %b", c, sc_addr, sc_is_writing, exp_addr, exp_we);
                end
            end
            if (busy_left > 0) busy_left--;
            else if (exp_gnt != 2'b00) begin
                exp_port = exp_gnt[1];
                last_d   = exp_gnt[1];
                a        = exp_gnt[1] ? d_addr : i_addr;
                we       = exp_gnt[1] & d_we;
                exp_addr = a;
                exp_we   = we;
                if (a >= MSZ || (a >= SRAM && we)) begin
                    busy_left = 1; exp_err = 1'b1; exp_data = 32'h0;
                end else if (resp_lat <= T) begin
                    busy_left = resp_lat + 1; exp_err = 1'b0; exp_data = we ? 32'h0 : mem_word(a);
                end else begin
                    busy_left = T + 1; exp_err = 1'b1; exp_data = 32'hDEAD_BEEF;
                end
            end
            tick();
            if (exp_gnt[0]) i_req = 1'b0;
            if (exp_gnt[1]) d_req = 1'b0;
        end
        i_req = 1'b0; d_req = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        i_addr = 32'h0; d_addr = 32'h0; d_we = 1'b0; d_be = 4'hF; d_wdata = 32'h0;
        test_reset();
        test_sram_read();
        test_errors();
        test_back_to_back();
        test_timeout();
        test_prog_mode();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
